// File: rtl/riscv_v_swizzle_seq.sv
// Sequencer around the combinational vector swizzle: reads a register group from one
// VRF read port (reverse register order when inverting), captures swizzle results in a
// 2-entry FIFO and drives VRF writebacks with valid/ready.
module riscv_v_swizzle_seq #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_OSIZES = 5,
  parameter int VREG_AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VREG_AW-1:0]    req_vs,
  input  logic [VREG_AW-1:0]    req_vd,
  input  logic [1:0]            req_lmul_log2,
  input  logic [2:0]            req_osize,
  input  logic                  req_invert,
  output logic                  vrf_rd_en,
  output logic [VREG_AW-1:0]    vrf_rd_addr,
  input  logic [DATA_WIDTH-1:0] vrf_rd_data,
  output logic [DATA_WIDTH-1:0] sw_src_data,
  output logic                  sw_invert,
  output logic [NUM_OSIZES-1:0] sw_osize_vec,
  input  logic [DATA_WIDTH-1:0] sw_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [VREG_AW-1:0]    wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [VREG_AW-1:0]    vs_q, vs_d, vd_q, vd_d;
  logic [1:0]            lmul_q, lmul_d;
  logic [2:0]            osize_q, osize_d;
  logic                  invert_q, invert_d;
  logic [3:0]            rd_cnt_q, rd_cnt_d;
  logic [3:0]            wr_cnt_q, wr_cnt_d;
  logic [3:0]            wb_cnt_q, wb_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  head_q, head_d, tail_q, tail_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [VREG_AW-1:0]    fifo_addr_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_q [2];

  logic [3:0]            grp_n_s;
  logic                  accept_s, legal_s, pop_s, push_s, rd_en_s, last_pop_s;
  logic [2:0]            level_s;
  logic [3:0]            rd_off_s;

  // Handshake, flow-control and read-offset decode
  always_comb begin
    grp_n_s    = 4'd1 << lmul_q;
    accept_s   = req_valid && (state_q == ST_IDLE);
    legal_s    = (req_osize <= 3'd4);
    pop_s      = (occ_q != 2'd0) && wb_ready;
    push_s     = inflight_q;
    // Occupancy the FIFO will have once the in-flight read lands and this cycle's pop retires
    level_s    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    rd_en_s    = (state_q == ST_RUN) && (rd_cnt_q < grp_n_s) && (level_s < 3'd2);
    last_pop_s = (state_q == ST_RUN) && pop_s && (wb_cnt_q == (grp_n_s - 4'd1));
    if (invert_q) begin
      rd_off_s = grp_n_s - 4'd1 - rd_cnt_q;
    end else begin
      rd_off_s = rd_cnt_q;
    end
  end

  // Next-state logic of the request FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = legal_s ? ST_RUN : ST_ERR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_pop_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next-state logic of request fields, counters and FIFO pointers
  always_comb begin
    vs_d       = vs_q;
    vd_d       = vd_q;
    lmul_d     = lmul_q;
    osize_d    = osize_q;
    invert_d   = invert_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    inflight_d = rd_en_s;
    occ_d      = occ_q + {1'b0, push_s} - {1'b0, pop_s};
    head_d     = pop_s ? ~head_q : head_q;
    tail_d     = push_s ? ~tail_q : tail_q;
    done_d     = last_pop_s || (accept_s && !legal_s);
    err_d      = accept_s && !legal_s;
    if (accept_s) begin
      vs_d     = req_vs;
      vd_d     = req_vd;
      lmul_d   = req_lmul_log2;
      osize_d  = req_osize;
      invert_d = req_invert;
      rd_cnt_d = 4'd0;
      wr_cnt_d = 4'd0;
      wb_cnt_d = 4'd0;
    end else begin
      rd_cnt_d = rd_en_s ? (rd_cnt_q + 4'd1) : rd_cnt_q;
      wr_cnt_d = push_s ? (wr_cnt_q + 4'd1) : wr_cnt_q;
      wb_cnt_d = pop_s ? (wb_cnt_q + 4'd1) : wb_cnt_q;
    end
  end

  // Control and request registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vs_q       <= {VREG_AW{1'b0}};
      vd_q       <= {VREG_AW{1'b0}};
      lmul_q     <= 2'd0;
      osize_q    <= 3'd0;
      invert_q   <= 1'b0;
      rd_cnt_q   <= 4'd0;
      wr_cnt_q   <= 4'd0;
      wb_cnt_q   <= 4'd0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      vd_q       <= vd_d;
      lmul_q     <= lmul_d;
      osize_q    <= osize_d;
      invert_q   <= invert_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Writeback FIFO storage: swizzle result lands in the cycle after the read strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_addr_q[0] <= {VREG_AW{1'b0}};
      fifo_addr_q[1] <= {VREG_AW{1'b0}};
      fifo_data_q[0] <= {DATA_WIDTH{1'b0}};
      fifo_data_q[1] <= {DATA_WIDTH{1'b0}};
    end else if (push_s) begin
      fifo_addr_q[tail_q] <= vd_q + VREG_AW'(wr_cnt_q);
      fifo_data_q[tail_q] <= sw_result;
    end else begin
      fifo_addr_q[tail_q] <= fifo_addr_q[tail_q];
      fifo_data_q[tail_q] <= fifo_data_q[tail_q];
    end
  end

  // Output drive; everything idles at zero outside an active request
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    vrf_rd_en   = rd_en_s;
    vrf_rd_addr = rd_en_s ? (vs_q + VREG_AW'(rd_off_s)) : {VREG_AW{1'b0}};
    sw_src_data = inflight_q ? vrf_rd_data : {DATA_WIDTH{1'b0}};
    sw_invert   = (state_q != ST_IDLE) && invert_q;
    for (int i = 0; i < NUM_OSIZES; i++) begin
      sw_osize_vec[i] = (state_q != ST_IDLE) && (osize_q == 3'(i));
    end
    wb_valid = (occ_q != 2'd0);
    wb_addr  = wb_valid ? fifo_addr_q[head_q] : {VREG_AW{1'b0}};
    wb_data  = wb_valid ? fifo_data_q[head_q] : {DATA_WIDTH{1'b0}};
    done     = done_q;
    err      = err_q;
  end

endmodule
